// File: rtl/accel_sample_scheduler.sv
// rtl/accel_sample_scheduler.sv - accelerometer sample timebase with req/ack sequencing
// Divides Clock_100MHz to the selected output data rate, tracks overruns/timeouts, emits a 1 Hz strobe.
module accel_sample_scheduler #(
  parameter int CLK_HZ      = 100000000,
  parameter int ACK_TIMEOUT = 1000000,
  parameter int OVR_W       = 8
) (
  input  logic             Clock_100MHz,
  input  logic             Clear,
  input  logic             Enable,
  input  logic [1:0]       Rate_Sel,
  input  logic             Sample_Ack,
  input  logic             Clear_Status,
  output logic             Sample_Req,
  output logic             Tick_1Hz,
  output logic             Busy,
  output logic [OVR_W-1:0] Overrun_Count,
  output logic             Timeout_Flag
);

  localparam logic [26:0] DIV_1HZ   = 27'(CLK_HZ / 1 - 1);
  localparam logic [26:0] DIV_10HZ  = 27'(CLK_HZ / 10 - 1);
  localparam logic [26:0] DIV_100HZ = 27'(CLK_HZ / 100 - 1);
  localparam logic [26:0] DIV_400HZ = 27'(CLK_HZ / 400 - 1);
  localparam int          TO_W      = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, REQ} state_t;

  state_t           state, state_nxt;
  logic [1:0]       rate_q;
  logic [26:0]      period_cnt;
  logic [26:0]      sec_cnt;
  logic [26:0]      div_sel;
  logic [TO_W-1:0]  to_cnt;
  logic             period_tick;
  logic             timeout_hit;
  logic             overrun_evt;
  logic             to_restart;

  always_comb begin
    div_sel = DIV_1HZ;
    case (rate_q)
      2'b00:   div_sel = DIV_1HZ;
      2'b01:   div_sel = DIV_10HZ;
      2'b10:   div_sel = DIV_100HZ;
      default: div_sel = DIV_400HZ;
    endcase
  end

  assign period_tick = (state != IDLE) && (period_cnt == div_sel);
  assign timeout_hit = Enable && (state == REQ) && !Sample_Ack && (to_cnt == TO_LAST);
  assign overrun_evt = Enable && (state == REQ) && period_tick && !Sample_Ack;
  // an ack landing on a period tick closes one request and opens the next in place
  assign to_restart  = (state == REQ) && Sample_Ack && period_tick;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Enable) state_nxt = WAIT;
      WAIT:    if (period_tick) state_nxt = REQ;
      REQ: begin
        if (Sample_Ack && !period_tick) state_nxt = WAIT;
        else if (timeout_hit)           state_nxt = WAIT;
      end
      default: state_nxt = IDLE;
    endcase
    if (!Enable) state_nxt = IDLE;
  end

  always_ff @(posedge Clock_100MHz) begin
    if (Clear) begin
      state         <= IDLE;
      rate_q        <= 2'b00;
      period_cnt    <= '0;
      sec_cnt       <= '0;
      to_cnt        <= '0;
      Overrun_Count <= '0;
      Timeout_Flag  <= 1'b0;
    end else begin
      state <= state_nxt;

      if (!Enable || state == IDLE || period_tick) period_cnt <= '0;
      else                                         period_cnt <= period_cnt + 27'd1;

      // rate only changes at a period boundary (or on leaving IDLE) so no runt periods
      if ((state == IDLE && Enable) || period_tick) rate_q <= Rate_Sel;

      if (state == REQ && state_nxt == REQ && !to_restart) to_cnt <= to_cnt + TO_W'(1);
      else                                                   to_cnt <= '0;

      if (!Enable || sec_cnt == DIV_1HZ) sec_cnt <= '0;
      else                               sec_cnt <= sec_cnt + 27'd1;

      if (overrun_evt) begin
        if (Clear_Status)            Overrun_Count <= OVR_W'(1);
        else if (&Overrun_Count)     Overrun_Count <= Overrun_Count;
        else                         Overrun_Count <= Overrun_Count + OVR_W'(1);
      end else if (Clear_Status) begin
        Overrun_Count <= '0;
      end

      if (timeout_hit)       Timeout_Flag <= 1'b1;
      else if (Clear_Status) Timeout_Flag <= 1'b0;
    end
  end

  assign Sample_Req = (state == REQ);
  assign Busy       = (state == REQ);
  assign Tick_1Hz   = Enable && (sec_cnt == DIV_1HZ);

endmodule
